mem_access: RTL and testbench

// - Memory-access stage: consumes the EX/MA pipeline register outputs (pc, rd, result, data1/data2, cause/tval, io ops).
// - Performs loads/stores on a 64-bit valid/ready data bus and stalls the pipeline while a memory op is in flight.
// - Formats load data and raises misaligned/access-fault causes. Registers the outcome into the MA/WB boundary.

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_access_load_align.sv | 28 ++
 rtl/mem_access.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: trap causes, access
// size encodings, FSM states and byte-lane helpers.
package mem_access_pkg;

   localparam logic [4:0] CAUSE_NONE  = 5'd0;
   localparam logic [4:0] LD_MISALIGN = 5'd4;
   localparam logic [4:0] LD_FAULT    = 5'd5;
   localparam logic [4:0] ST_MISALIGN = 5'd6;
   localparam logic [4:0] ST_FAULT    = 5'd7;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } ma_state_t;

   // Low address bits that must be zero for an access of this size.
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      case (size)
         SIZE_B:  align_mask = 3'b000;
         SIZE_H:  align_mask = 3'b001;
         SIZE_W:  align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
   endfunction

   // Byte enables for an access of this size starting at byte lane a.
   function automatic logic [7:0] lane_strb(input logic [1:0] size, input logic [2:0] a);
      case (size)
         SIZE_B:  lane_strb = 8'h01 << a;
         SIZE_H:  lane_strb = 8'h03 << a;
         SIZE_W:  lane_strb = 8'h0F << a;
         default: lane_strb = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data formatter: moves the addressed bytes of the returned doubleword
// down to bit 0 and sign- or zero-extends them to 64 bits.
module mem_access_load_align
   import mem_access_pkg::*;
(
   input  logic [63:0] rdata_i,
   input  logic [2:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [63:0] value_o
);

   logic [63:0] shifted;

   assign shifted = rdata_i >> {lane_i, 3'b000};

   // Select the access width and extend it.
   always_comb begin
      value_o = shifted;
      case (size_i)
         SIZE_B:  value_o = unsigned_i ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         SIZE_H:  value_o = unsigned_i ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         SIZE_W:  value_o = unsigned_i ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: value_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Non-memory and trapping ops pass through
// the MA/WB register in one cycle; loads and stores run one bus
// transaction (IDLE -> REQ -> WAIT) while the upstream pipeline is stalled.
// Bus handshake: a request is transferred on a cycle where mem_req_valid
// and mem_req_ready are both high; the request fields stay stable from
// valid rising until that cycle. The response is a single beat marked by
// mem_rsp_valid and is only accepted in WAIT.
// While stalled the MA/WB register holds bubbles, so the op retires once.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [63:0]       pc_in,
   input  logic [4:0]        rd_in,
   input  logic [63:0]       result_in,
   input  logic [63:0]       data2_in,
   input  logic [4:0]        cause_in,
   input  logic [63:0]       tval_in,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   output logic              stall_out,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [7:0]        mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   input  logic              mem_rsp_err,
   output logic [63:0]       pc_out,
   output logic [4:0]        rd_out,
   output logic [63:0]       result_out,
   output logic [4:0]        cause_out,
   output logic [63:0]       tval_out,
   output logic [1:0]        dbg_state_o
);

   ma_state_t   state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [63:0] pc_q, pc_d;
   logic [4:0]  rd_q, rd_d;
   logic        kill_q, kill_d;

   logic [63:0] pc_out_q, pc_out_d;
   logic [4:0]  rd_out_q, rd_out_d;
   logic [63:0] result_out_q, result_out_d;
   logic [4:0]  cause_out_q, cause_out_d;
   logic [63:0] tval_out_q, tval_out_d;

   logic        is_mem, has_cause, misaligned, kill_now;
   logic [63:0] load_val;

   assign is_mem     = is_load | is_store;
   assign has_cause  = (cause_in != CAUSE_NONE);
   assign misaligned = is_mem && ((result_in[2:0] & align_mask(size)) != 3'b000);
   assign kill_now   = kill_q | clear;

   mem_access_load_align u_load_align (
      .rdata_i    (mem_rsp_rdata),
      .lane_i     (addr_q[2:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .value_o    (load_val)
   );

   assign mem_req_valid = (state_q == REQ);
   assign mem_req_we    = we_q;
   assign mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
   assign mem_req_wdata = wdata_q;
   assign mem_req_wstrb = wstrb_q;

   assign pc_out      = pc_out_q;
   assign rd_out      = rd_out_q;
   assign result_out  = result_out_q;
   assign cause_out   = cause_out_q;
   assign tval_out    = tval_out_q;
   assign dbg_state_o = state_q;

   // Next state, captured request fields, stall and MA/WB register input.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      pc_d         = pc_q;
      rd_d         = rd_q;
      kill_d       = kill_q;
      stall_out    = 1'b0;
      pc_out_d     = 64'd0;
      rd_out_d     = 5'd0;
      result_out_d = 64'd0;
      cause_out_d  = CAUSE_NONE;
      tval_out_d   = 64'd0;
      case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (clear) begin
               // flushed: bubble, nothing issued
            end else if (has_cause) begin
               pc_out_d     = pc_in;
               result_out_d = result_in;
               cause_out_d  = cause_in;
               tval_out_d   = tval_in;
            end else if (misaligned) begin
               pc_out_d     = pc_in;
               result_out_d = result_in;
               cause_out_d  = is_load ? LD_MISALIGN : ST_MISALIGN;
               tval_out_d   = result_in;
            end else if (is_mem) begin
               stall_out = 1'b1;
               state_d   = REQ;
               addr_d    = result_in;
               wdata_d   = data2_in << {result_in[2:0], 3'b000};
               wstrb_d   = lane_strb(size, result_in[2:0]);
               we_d      = !is_load;
               size_d    = size;
               uns_d     = is_unsigned;
               pc_d      = pc_in;
               rd_d      = rd_in;
            end else begin
               pc_out_d     = pc_in;
               rd_out_d     = rd_in;
               result_out_d = result_in;
               tval_out_d   = tval_in;
            end
         end
         REQ: begin
            stall_out = 1'b1;
            kill_d    = kill_now;
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            stall_out = !mem_rsp_valid;
            kill_d    = kill_now;
            if (mem_rsp_valid) begin
               state_d = IDLE;
               if (!kill_now) begin
                  pc_out_d = pc_q;
                  if (mem_rsp_err) begin
                     cause_out_d = we_q ? ST_FAULT : LD_FAULT;
                     tval_out_d  = addr_q;
                  end else if (!we_q) begin
                     rd_out_d     = rd_q;
                     result_out_d = load_val;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) stall_out = 1'b0;
   end

   // State, request and MA/WB registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         wstrb_q      <= 8'd0;
         we_q         <= 1'b0;
         size_q       <= SIZE_B;
         uns_q        <= 1'b0;
         pc_q         <= 64'd0;
         rd_q         <= 5'd0;
         kill_q       <= 1'b0;
         pc_out_q     <= 64'd0;
         rd_out_q     <= 5'd0;
         result_out_q <= 64'd0;
         cause_out_q  <= CAUSE_NONE;
         tval_out_q   <= 64'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         pc_q         <= pc_d;
         rd_q         <= rd_d;
         kill_q       <= kill_d;
         pc_out_q     <= pc_out_d;
         rd_out_q     <= rd_out_d;
         result_out_q <= result_out_d;
         cause_out_q  <= cause_out_d;
         tval_out_q   <= tval_out_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the memory-access stage. Inputs change 1ns after the
// rising edge; combinational outputs are checked 1ns later, registered
// outputs 1ns after the edge that loads them.
module tb_mem_access;

   logic        clk;
   logic        rst;
   logic        clear;
   logic [63:0] pc_in, result_in, data2_in, tval_in;
   logic [4:0]  rd_in, cause_in;
   logic        is_load, is_store, is_unsigned;
   logic [1:0]  size;
   logic        stall_out, mem_req_valid, mem_req_ready, mem_req_we;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_rsp_valid, mem_rsp_err;
   logic [63:0] mem_rsp_rdata;
   logic [63:0] pc_out, result_out, tval_out;
   logic [4:0]  rd_out, cause_out;
   logic [1:0]  dbg_state_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];

   mem_access dut (
      .clk(clk), .rst(rst), .clear(clear),
      .pc_in(pc_in), .rd_in(rd_in), .result_in(result_in), .data2_in(data2_in),
      .cause_in(cause_in), .tval_in(tval_in),
      .is_load(is_load), .is_store(is_store), .size(size), .is_unsigned(is_unsigned),
      .stall_out(stall_out),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
      .pc_out(pc_out), .rd_out(rd_out), .result_out(result_out),
      .cause_out(cause_out), .tval_out(tval_out),
      .dbg_state_o(dbg_state_o)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      clear       = 1'b0;
      pc_in       = 64'd0;
      rd_in       = 5'd0;
      result_in   = 64'd0;
      data2_in    = 64'd0;
      cause_in    = 5'd0;
      tval_in     = 64'd0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      size        = 2'd0;
      is_unsigned = 1'b0;
   endtask

   task automatic drive_op(input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] d2, input logic [4:0] rd);
      is_load     = ld;
      is_store    = !ld;
      size        = sz;
      is_unsigned = uns;
      result_in   = addr;
      data2_in    = d2;
      rd_in       = rd;
      pc_in       = 64'h8000_0000 + addr;
      cause_in    = 5'd0;
      tval_in     = 64'd0;
   endtask

   // One full bus transaction with a directed bus response and expected result.
   task automatic mem_op(input string name, input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] d2, input logic [4:0] rd,
                         input int rdy_wait, input int rsp_wait, input logic [63:0] rdata,
                         input logic err, input logic clr,
                         input logic [4:0] exp_rd, input logic [63:0] exp_res,
                         input logic [4:0] exp_cause, input logic [63:0] exp_tval,
                         input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
      logic [63:0] exp_addr;
      exp_addr = addr & ~64'h7;
      exp_q.push_back(exp_res);
      drive_op(ld, sz, uns, addr, d2, rd);
      #1;
      check({name, " issue stall"}, stall_out, 1'b1);
      check({name, " issue valid"}, mem_req_valid, 1'b0);
      step();
      for (int k = 0; k < rdy_wait; k++) begin
         mem_rsp_valid = (k == 0);
         #1;
         check({name, " req valid"}, mem_req_valid, 1'b1);
         check({name, " req addr"}, mem_req_addr, exp_addr);
         check({name, " req stall"}, stall_out, 1'b1);
         if (!ld) begin
            check({name, " req wstrb"}, mem_req_wstrb, exp_strb);
            check({name, " req wdata"}, mem_req_wdata, exp_wdata);
         end
         step();
         mem_rsp_valid = 1'b0;
      end
      mem_req_ready = 1'b1;
      #1;
      check({name, " accept valid"}, mem_req_valid, 1'b1);
      check({name, " accept addr"}, mem_req_addr, exp_addr);
      check({name, " accept we"}, mem_req_we, !ld);
      check({name, " accept stall"}, stall_out, 1'b1);
      if (!ld) begin
         check({name, " accept wstrb"}, mem_req_wstrb, exp_strb);
         check({name, " accept wdata"}, mem_req_wdata, exp_wdata);
      end
      step();
      mem_req_ready = 1'b0;
      for (int j = 0; j < rsp_wait; j++) begin
         clear = clr && (j == 0);
         #1;
         check({name, " wait stall"}, stall_out, 1'b1);
         check({name, " wait valid"}, mem_req_valid, 1'b0);
         step();
         clear = 1'b0;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      mem_rsp_err   = err;
      #1;
      check({name, " rsp stall"}, stall_out, 1'b0);
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      drive_idle();
      check({name, " result"}, result_out, exp_q.pop_front());
      check({name, " rd"}, rd_out, exp_rd);
      check({name, " cause"}, cause_out, exp_cause);
      check({name, " tval"}, tval_out, exp_tval);
      check({name, " pc"}, pc_out, clr ? 64'd0 : 64'h8000_0000 + addr);
      check({name, " back idle"}, dbg_state_o, 2'd0);
   endtask

   initial begin
      rst           = 1'b1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 64'd0;
      mem_rsp_err   = 1'b0;
      drive_idle();
      step();
      step();
      check("reset rd", rd_out, 5'd0);
      check("reset pc", pc_out, 64'd0);
      check("reset result", result_out, 64'd0);
      check("reset cause", cause_out, 5'd0);
      check("reset tval", tval_out, 64'd0);
      check("reset valid", mem_req_valid, 1'b0);
      check("reset stall", stall_out, 1'b0);
      check("reset state", dbg_state_o, 2'd0);
      rst = 1'b0;
      step();

      // Non-memory op passes through in one cycle.
      pc_in = 64'h400; rd_in = 5'd9; result_in = 64'hDEAD_BEEF;
      #1;
      check("alu stall", stall_out, 1'b0);
      step();
      drive_idle();
      check("alu rd", rd_out, 5'd9);
      check("alu result", result_out, 64'hDEAD_BEEF);
      check("alu pc", pc_out, 64'h400);
      check("alu cause", cause_out, 5'd0);

      mem_op("ld", 1, 2'd3, 0, 64'h1008, 64'd0, 5'd3, 0, 1, 64'h8877665544332211, 0, 0,
             5'd3, 64'h8877665544332211, 5'd0, 64'd0, 8'h00, 64'd0);
      mem_op("lb", 1, 2'd0, 0, 64'h100F, 64'd0, 5'd4, 0, 1, 64'h80AABBCCDDEEFF11, 0, 0,
             5'd4, 64'hFFFF_FFFF_FFFF_FF80, 5'd0, 64'd0, 8'h00, 64'd0);
      mem_op("lbu", 1, 2'd0, 1, 64'h100F, 64'd0, 5'd4, 0, 1, 64'h80AABBCCDDEEFF11, 0, 0,
             5'd4, 64'h80, 5'd0, 64'd0, 8'h00, 64'd0);
      mem_op("lh", 1, 2'd1, 0, 64'h1006, 64'd0, 5'd6, 1, 0, 64'hF00D_0000_0000_0000, 0, 0,
             5'd6, 64'hFFFF_FFFF_FFFF_F00D, 5'd0, 64'd0, 8'h00, 64'd0);
      mem_op("lwu", 1, 2'd2, 1, 64'h1004, 64'd0, 5'd10, 0, 2, 64'h89AB_CDEF_0000_0000, 0, 0,
             5'd10, 64'h89AB_CDEF, 5'd0, 64'd0, 8'h00, 64'd0);
      mem_op("lw", 1, 2'd2, 0, 64'h1004, 64'd0, 5'd11, 0, 0, 64'h89AB_CDEF_0000_0000, 0, 0,
             5'd11, 64'hFFFF_FFFF_89AB_CDEF, 5'd0, 64'd0, 8'h00, 64'd0);
      mem_op("sh", 0, 2'd1, 0, 64'h1002, 64'hABCD, 5'd7, 2, 1, 64'd0, 0, 0,
             5'd0, 64'd0, 5'd0, 64'd0, 8'h0C, 64'h0000_0000_ABCD_0000);
      mem_op("sb", 0, 2'd0, 0, 64'h3005, 64'hEE, 5'd0, 1, 1, 64'd0, 0, 0,
             5'd0, 64'd0, 5'd0, 64'd0, 8'h20, 64'h0000_EE00_0000_0000);
      mem_op("sw", 0, 2'd2, 0, 64'h1004, 64'hCAFE_BABE, 5'd0, 0, 1, 64'd0, 0, 0,
             5'd0, 64'd0, 5'd0, 64'd0, 8'hF0, 64'hCAFE_BABE_0000_0000);
      mem_op("sd err", 0, 2'd3, 0, 64'h2000, 64'h1122334455667788, 5'd12, 5, 1, 64'd0, 1, 0,
             5'd0, 64'd0, 5'd7, 64'h2000, 8'hFF, 64'h1122334455667788);
      mem_op("ld err", 1, 2'd3, 0, 64'h2010, 64'd0, 5'd13, 0, 1, 64'h1234, 1, 0,
             5'd0, 64'd0, 5'd5, 64'h2010, 8'h00, 64'd0);
      mem_op("ld clear", 1, 2'd3, 0, 64'h1010, 64'd0, 5'd5, 1, 2, 64'h5555, 0, 1,
             5'd0, 64'd0, 5'd0, 64'd0, 8'h00, 64'd0);

      // Misaligned load: trap, no bus request, no stall.
      drive_op(1, 2'd2, 0, 64'h1006, 64'd0, 5'd8);
      #1;
      check("lw mis stall", stall_out, 1'b0);
      check("lw mis valid", mem_req_valid, 1'b0);
      step();
      drive_idle();
      #1;
      check("lw mis cause", cause_out, 5'd4);
      check("lw mis tval", tval_out, 64'h1006);
      check("lw mis rd", rd_out, 5'd0);
      check("lw mis no req", mem_req_valid, 1'b0);
      check("lw mis stall2", stall_out, 1'b0);

      // Misaligned store.
      drive_op(0, 2'd1, 0, 64'h1001, 64'h77, 5'd0);
      #1;
      check("sh mis stall", stall_out, 1'b0);
      step();
      drive_idle();
      check("sh mis cause", cause_out, 5'd6);
      check("sh mis tval", tval_out, 64'h1001);
      check("sh mis state", dbg_state_o, 2'd0);

      // Earlier-stage cause wins over misalignment.
      drive_op(1, 2'd3, 0, 64'h1003, 64'd0, 5'd14);
      cause_in = 5'd2;
      tval_in  = 64'h55;
      #1;
      check("cause stall", stall_out, 1'b0);
      step();
      drive_idle();
      check("cause out", cause_out, 5'd2);
      check("cause tval", tval_out, 64'h55);
      check("cause rd", rd_out, 5'd0);
      check("cause valid", mem_req_valid, 1'b0);

      // Reset while a request is pending.
      drive_op(1, 2'd3, 0, 64'h1018, 64'd0, 5'd15);
      step();
      check("rst pre valid", mem_req_valid, 1'b1);
      rst = 1'b1;
      step();
      check("rst req valid", mem_req_valid, 1'b0);
      check("rst req stall", stall_out, 1'b0);
      check("rst req state", dbg_state_o, 2'd0);
      drive_idle();
      rst = 1'b0;
      step();
      check("post rst valid", mem_req_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
